// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, word type and pipeline bubble constants.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    typedef logic [DATA_W-1:0] word_t;

    localparam word_t NOP_INSTR = word_t'(16'h0000);
    localparam word_t RST_PC    = word_t'(16'h0000);

endpackage : cpu_pkg

// File: rtl/fetch_decode_reg_if.sv
// Fetch -> Decode pipeline register bus.
//   master : fetch-side driver (Stall, Flush, NextPCIn, InstructIn), sees registered outputs
//   slave  : the pipeline register itself
// Optional macro FETCH_REG_STALL_CNT_EN adds the StallCnt observation output.
interface fetch_decode_reg_if #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
);
    logic              Stall;
    logic              Flush;
    logic [DATA_W-1:0] NextPCIn;
    logic [DATA_W-1:0] InstructIn;
    logic [DATA_W-1:0] NextPCOut;
    logic [DATA_W-1:0] InstructOut;
    logic              ValidOut;
`ifdef FETCH_REG_STALL_CNT_EN
    logic [cpu_pkg::CNT_W-1:0] StallCnt;
`endif

    modport master (
        output Stall, Flush, NextPCIn, InstructIn,
        input  NextPCOut, InstructOut, ValidOut
`ifdef FETCH_REG_STALL_CNT_EN
        , input StallCnt
`endif
    );

    modport slave (
        input  Stall, Flush, NextPCIn, InstructIn,
        output NextPCOut, InstructOut, ValidOut
`ifdef FETCH_REG_STALL_CNT_EN
        , output StallCnt
`endif
    );

endinterface : fetch_decode_reg_if

// File: rtl/fetch_decode_reg_en_reg.sv
// pipe_en_reg: width-parameterised register with async active-low reset,
// synchronous clear (priority over enable) and load enable.
//   clk, rst : clock, async active-low reset to RST_VAL
//   clr      : load RST_VAL at the edge
//   en       : load d at the edge
//   d, q     : data in, registered data out
module pipe_en_reg #(
    parameter int unsigned W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_en_reg

// File: rtl/fetch_decode_reg.sv
// Fetch -> Decode pipeline register. Captures PC+1 and the instruction word,
// holds on Stall, inserts a bubble (NOP, RST_PC, invalid) on Flush.
// Priority per edge: Flush > Stall > load. All outputs come straight from flops.
//   clk  : rising-edge clock
//   rst  : async active-low reset
//   bus  : fetch_decode_reg_if.slave (Stall, Flush, NextPCIn, InstructIn ->
//          NextPCOut, InstructOut, ValidOut)
// Optional macro FETCH_REG_STALL_CNT_EN: saturating 16-bit count of stalled edges
// on bus.StallCnt (not cleared by Flush).
module fetch_decode_reg #(
    parameter int unsigned      DATA_W    = cpu_pkg::DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
    parameter logic [DATA_W-1:0] RST_PC    = cpu_pkg::RST_PC
) (
    input  logic               clk,
    input  logic               rst,
    fetch_decode_reg_if.slave  bus
);
    import cpu_pkg::*;

    // Flush clears regardless of Stall; otherwise load only when not stalled.
    logic clrC;
    logic enC;
    assign clrC = bus.Flush;
    assign enC  = ~bus.Stall;

    pipe_en_reg #(.W(DATA_W), .RST_VAL(RST_PC)) uNextPC (
        .clk (clk),
        .rst (rst),
        .clr (clrC),
        .en  (enC),
        .d   (bus.NextPCIn),
        .q   (bus.NextPCOut)
    );

    pipe_en_reg #(.W(DATA_W), .RST_VAL(NOP_INSTR)) uInstruct (
        .clk (clk),
        .rst (rst),
        .clr (clrC),
        .en  (enC),
        .d   (bus.InstructIn),
        .q   (bus.InstructOut)
    );

    pipe_en_reg #(.W(1), .RST_VAL(1'b0)) uValid (
        .clk (clk),
        .rst (rst),
        .clr (clrC),
        .en  (enC),
        .d   (1'b1),
        .q   (bus.ValidOut)
    );

`ifdef FETCH_REG_STALL_CNT_EN
    // Counts edges that actually held the register; saturates instead of wrapping.
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (bus.Stall && !bus.Flush && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign bus.StallCnt = stallCnt;
`endif

endmodule : fetch_decode_reg

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: directed steps plus random traffic against a
// behavioural model of the pipeline register.
module tb_fetch_decode_reg;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_decode_reg_if #(.DATA_W(DATA_W)) bus ();

    fetch_decode_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passCnt  = 0;
    int failCnt  = 0;
    int totalCnt = 0;

    // Model state: what Decode should currently see.
    word_t mPc;
    word_t mIns;
    logic  mValid;
    int    mCnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, ".pc"},    32'(bus.NextPCOut),   32'(mPc));
        check({tag, ".instr"}, 32'(bus.InstructOut), 32'(mIns));
        check({tag, ".valid"}, 32'(bus.ValidOut),    32'(mValid));
`ifdef FETCH_REG_STALL_CNT_EN
        check({tag, ".cnt"},   32'(bus.StallCnt),    32'(mCnt));
`endif
    endtask

    task automatic modelReset();
        mPc    = RST_PC;
        mIns   = NOP_INSTR;
        mValid = 1'b0;
        mCnt   = 0;
    endtask

    // Drive inputs, take one edge, advance the model, settle away from the edge.
    task automatic edgeStep(input logic s, input logic f, input word_t pc, input word_t ins);
        bus.Stall      = s;
        bus.Flush      = f;
        bus.NextPCIn   = pc;
        bus.InstructIn = ins;
        @(posedge clk);
        if (f) begin
            mPc    = RST_PC;
            mIns   = NOP_INSTR;
            mValid = 1'b0;
        end else if (!s) begin
            mPc    = pc;
            mIns   = ins;
            mValid = 1'b1;
        end
        if (s && !f && mCnt < 65535) mCnt++;
        #1;
    endtask

    initial begin
        bus.Stall      = 1'b0;
        bus.Flush      = 1'b0;
        bus.NextPCIn   = 16'h1234;
        bus.InstructIn = 16'hABCD;

        // Asynchronous reset seen before the first clock edge.
        #1 rst = 1'b0;
        modelReset();
        #1 checkAll("reset_async");
        check("reset_async_pc_const", 32'(bus.NextPCOut), 32'h0);

        repeat (2) @(posedge clk);
        #1 checkAll("reset_hold");

        // Unknown control while in reset must not disturb the outputs.
        bus.Stall = 1'bx;
        bus.Flush = 1'bx;
        @(posedge clk);
        #1 checkAll("reset_x_ctrl");
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        rst = 1'b1;

        // Single load, one-cycle latency.
        edgeStep(1'b0, 1'b0, 16'h0005, 16'h8A21);
        checkAll("load");
        check("load_instr_const", 32'(bus.InstructOut), 32'h8A21);

        // Stall for three edges while inputs change.
        for (int i = 0; i < 3; i++) begin
            edgeStep(1'b1, 1'b0, 16'h0006, 16'h1111);
            check("stall_pc_const",    32'(bus.NextPCOut),   32'h0005);
            check("stall_instr_const", 32'(bus.InstructOut), 32'h8A21);
        end
        edgeStep(1'b0, 1'b0, 16'h0006, 16'h1111);
        checkAll("stall_release");
        check("release_instr_const", 32'(bus.InstructOut), 32'h1111);

        // Flush beats stall.
        edgeStep(1'b1, 1'b1, 16'h0007, 16'h2222);
        checkAll("flush_stall");
        check("flush_valid_const", 32'(bus.ValidOut), 32'h0);

        // Wrapped PC stored verbatim.
        edgeStep(1'b0, 1'b0, 16'h0000, 16'h4321);
        checkAll("wrap_pc");
        check("wrap_valid_const", 32'(bus.ValidOut), 32'h1);

        // Reset pulse between edges mid-stream.
        edgeStep(1'b0, 1'b0, 16'h0055, 16'h0066);
        checkAll("pre_async");
        #2 rst = 1'b0;
        modelReset();
        #1 checkAll("async_mid");
        rst = 1'b1;

`ifdef FETCH_REG_STALL_CNT_EN
        // Five stall edges, one of them flushed.
        edgeStep(1'b1, 1'b0, 16'h0001, 16'h0001);
        edgeStep(1'b1, 1'b0, 16'h0002, 16'h0002);
        edgeStep(1'b1, 1'b1, 16'h0003, 16'h0003);
        edgeStep(1'b1, 1'b0, 16'h0004, 16'h0004);
        edgeStep(1'b1, 1'b0, 16'h0005, 16'h0005);
        check("cnt_five_stalls", 32'(bus.StallCnt), 32'd4);
`endif

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 300; i++) begin
            edgeStep(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                     word_t'($urandom), word_t'($urandom));
            checkAll("rand");
            if ($urandom_range(0, 29) == 0) begin
                #2 rst = 1'b0;
                modelReset();
                #1 checkAll("rand_rst");
                rst = 1'b1;
            end
        end

`ifdef FETCH_REG_STALL_CNT_EN
        // Saturation: reset, run up to 16'hFFFE, then three more stalls.
        #2 rst = 1'b0;
        modelReset();
        #1 check("cnt_reset", 32'(bus.StallCnt), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            edgeStep(1'b1, 1'b0, 16'h0000, 16'h0000);
        end
        check("cnt_preload", 32'(bus.StallCnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            edgeStep(1'b1, 1'b0, 16'h0000, 16'h0000);
        end
        check("cnt_saturate", 32'(bus.StallCnt), 32'h0000_FFFF);
        checkAll("cnt_saturate_model");
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule : tb_fetch_decode_reg
